// File: rtl/flag_branch_unit_if.sv
// ALU result/flag and branch-resolution bundle between the execute stage and
// the flag/branch unit. The slave side is the flag_branch_unit itself.
interface flag_branch_unit_if;
  // ALU result side
  logic        alu_valid;
  logic [3:0]  aluOp;
  logic [15:0] alu_dst;
  logic        alu_ov;
  logic        alu_zr;
  // Branch request side
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  // Results
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        br_taken;
  logic [15:0] br_pc;
  logic        flush_out;
  logic        busy;

  modport slave (
    input  alu_valid, aluOp, alu_dst, alu_ov, alu_zr,
    input  br_valid, br_cond, br_target,
    output flag_z, flag_v, flag_n, br_taken, br_pc, flush_out, busy
  );

  modport master (
    output alu_valid, aluOp, alu_dst, alu_ov, alu_zr,
    output br_valid, br_cond, br_target,
    input  flag_z, flag_v, flag_n, br_taken, br_pc, flush_out, busy
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Execute-stage flag/branch unit: captures ALU zero/overflow/sign into the
// architectural Z/V/N flags, resolves conditional branches against them and
// issues a one-cycle redirect plus a FLUSH_CYCLES-long flush of younger stages.
module flag_branch_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          FWD_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush_in,
  flag_branch_unit_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_NOR = 4'h3;
  localparam logic [3:0] ALU_SLL = 4'h4;
  localparam logic [3:0] ALU_SRL = 4'h5;
  localparam logic [3:0] ALU_SRA = 4'h6;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_z, r_v, r_n;
  logic        r_br_taken;
  logic [15:0] r_br_pc;
  logic        r_flush_out;
  logic        r_busy;

  logic w_upd;
  logic w_z_nxt, w_v_nxt, w_n_nxt;
  logic w_z_eff, w_v_eff, w_n_eff;
  logic w_cond;
  logic w_take;

  // An ALU result only touches the flags from a live, unsquashed IDLE cycle.
  assign w_upd = bus.alu_valid & ~stall & ~flush_in & (r_state == IDLE);

  // Next-state flags according to the per-opcode update rules.
  always_comb begin
    w_z_nxt = r_z;
    w_v_nxt = r_v;
    w_n_nxt = r_n;
    if (w_upd) begin
      case (bus.aluOp)
        ALU_ADD, ALU_SUB: begin
          w_z_nxt = bus.alu_zr;
          w_v_nxt = bus.alu_ov;
          w_n_nxt = bus.alu_dst[15];
        end
        ALU_AND, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA: begin
          w_z_nxt = bus.alu_zr;
        end
        default: begin
          w_z_nxt = r_z;
        end
      endcase
    end
  end

  // Without an update the next-state flags equal the registered ones, so the
  // bypass reduces to a plain select on FWD_EN.
  assign w_z_eff = FWD_EN ? w_z_nxt : r_z;
  assign w_v_eff = FWD_EN ? w_v_nxt : r_v;
  assign w_n_eff = FWD_EN ? w_n_nxt : r_n;

  // Condition-code evaluation against the effective flags.
  always_comb begin
    w_cond = 1'b0;
    case (bus.br_cond)
      3'b000:  w_cond = ~w_z_eff;
      3'b001:  w_cond = w_z_eff;
      3'b010:  w_cond = ~w_z_eff & ~w_n_eff;
      3'b011:  w_cond = w_n_eff;
      3'b100:  w_cond = w_z_eff | ~w_n_eff;
      3'b101:  w_cond = w_n_eff | w_z_eff;
      3'b110:  w_cond = w_v_eff;
      default: w_cond = 1'b1;
    endcase
  end

  assign w_take = (r_state == IDLE) & bus.br_valid & w_cond & ~stall & ~flush_in;

  // Architectural flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= 1'b0;
      r_v <= 1'b0;
      r_n <= 1'b0;
    end else if (w_upd) begin
      r_z <= w_z_nxt;
      r_v <= w_v_nxt;
      r_n <= w_n_nxt;
    end
  end

  // Redirect/flush FSM; br_taken is cleared every edge so the pulse survives
  // neither stall nor flush_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_br_taken  <= 1'b0;
      r_br_pc     <= '0;
      r_flush_out <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_br_taken <= 1'b0;
      if (flush_in) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_flush_out <= 1'b0;
        r_busy      <= 1'b0;
      end else if (!stall) begin
        case (r_state)
          IDLE: begin
            if (w_take) begin
              r_br_taken  <= 1'b1;
              r_br_pc     <= bus.br_target;
              r_flush_out <= 1'b1;
              r_busy      <= 1'b1;
              r_cnt       <= CNT_INIT;
              r_state     <= FLUSH;
            end
          end
          FLUSH: begin
            if (r_cnt == 3'd0) begin
              r_state     <= IDLE;
              r_flush_out <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.flag_z    = r_z;
  assign bus.flag_v    = r_v;
  assign bus.flag_n    = r_n;
  assign bus.br_taken  = r_br_taken;
  assign bus.br_pc     = r_br_pc;
  assign bus.flush_out = r_flush_out;
  assign bus.busy      = r_busy;

endmodule
